// File: rtl/fifo_pkg.sv
// Shared constants for the sync FIFO controller: default geometry, pointer
// width helper and reset values of the registered status outputs.
package fifo_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;
   localparam int DATA_W     = 8;
   localparam int PTR_W_DEF  = ADDR_W_DEF + 1;

   localparam logic RST_EMPTY = 1'b1;
   localparam logic RST_FULL  = 1'b0;
   localparam logic RST_VALID = 1'b0;
   localparam logic RST_PULSE = 1'b0;
   localparam logic RST_AF    = 1'b0;
   localparam logic RST_AE    = 1'b1;

   // Pointers carry one wrap bit above the RAM address.
   function automatic int ptr_w(input int addr_w);
      return addr_w + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Request/status bundle between the requesting logic and sync_fifo_ctrl.
// Almost-full/empty signals exist only when FIFO_ALMOST_FLAGS_EN is defined.
interface sync_fifo_ctrl_if
   import fifo_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
);

   logic              w_en;
   logic              r_en;
   logic              ram_w_en;
   logic [ADDR_W-1:0] ram_w_addr;
   logic [ADDR_W-1:0] ram_r_addr;
   logic              r_valid;
   logic              w_full;
   logic              r_empty;
   logic [ADDR_W:0]   fifo_cnt;
   logic              ovf;
   logic              udf;
`ifdef FIFO_ALMOST_FLAGS_EN
   logic              almost_full;
   logic              almost_empty;
`endif

   // Requester side: issues push/pop, observes status.
   modport master (
      output w_en, r_en,
      input  ram_w_en, ram_w_addr, ram_r_addr, r_valid,
             w_full, r_empty, fifo_cnt, ovf, udf
`ifdef FIFO_ALMOST_FLAGS_EN
      , input almost_full, almost_empty
`endif
   );

   // Controller side.
   modport slave (
      input  w_en, r_en,
      output ram_w_en, ram_w_addr, ram_r_addr, r_valid,
             w_full, r_empty, fifo_cnt, ovf, udf
`ifdef FIFO_ALMOST_FLAGS_EN
      , output almost_full, almost_empty
`endif
   );

endinterface

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer counter: increments on inc, exposes the next value so the
// parent can register flags that are already correct after the edge.
module fifo_ptr
   import fifo_pkg::*;
#(
   parameter int PTR_W = PTR_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] ptr_nxt
);

   assign ptr_nxt = ptr + PTR_W'(inc);

   // Pointer register, rolls over modulo 2**PTR_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr <= '0;
      else        ptr <= ptr_nxt;
   end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Pointer/flag controller for a 16x8 dual-port RAM FIFO on a single clock.
// Optional almost-full/almost-empty flags: define FIFO_ALMOST_FLAGS_EN.
module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int AF_LVL = 14,
   parameter int AE_LVL = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   sync_fifo_ctrl_if.slave   bus
);

   localparam int PW = ptr_w(ADDR_W);

   if (DEPTH != (1 << ADDR_W)) begin : g_depth_chk
      $error("sync_fifo_ctrl: DEPTH must equal 2**ADDR_W");
   end
   if (AF_LVL < 0 || AF_LVL > DEPTH || AE_LVL < 0 || AE_LVL > DEPTH) begin : g_lvl_chk
      $error("sync_fifo_ctrl: almost thresholds out of range");
   end

   logic [PW-1:0]   wr_ptr, wr_nxt, rd_ptr, rd_nxt;
   logic            push_ok, pop_ok;
   logic            full_q, empty_q, rv_q, ovf_q, udf_q;
   logic [ADDR_W:0] cnt_q, cnt_nxt;

   // Acceptance uses current flags, so a push at full or pop at empty is dropped.
   assign push_ok = bus.w_en & ~full_q;
   assign pop_ok  = bus.r_en & ~empty_q;

   fifo_ptr #(.PTR_W(PW)) u_wr_ptr (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (push_ok),
      .ptr     (wr_ptr),
      .ptr_nxt (wr_nxt)
   );

   fifo_ptr #(.PTR_W(PW)) u_rd_ptr (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (pop_ok),
      .ptr     (rd_ptr),
      .ptr_nxt (rd_nxt)
   );

   // Occupancy moves only when exactly one side is accepted.
   always_comb begin
      cnt_nxt = cnt_q;
      case ({push_ok, pop_ok})
         2'b10:   cnt_nxt = cnt_q + 1'b1;
         2'b01:   cnt_nxt = cnt_q - 1'b1;
         default: cnt_nxt = cnt_q;
      endcase
   end

   // Status registers, derived from next-state pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q  <= RST_FULL;
         empty_q <= RST_EMPTY;
         cnt_q   <= '0;
         rv_q    <= RST_VALID;
         ovf_q   <= RST_PULSE;
         udf_q   <= RST_PULSE;
      end else begin
         full_q  <= (wr_nxt[PW-1] != rd_nxt[PW-1]) &&
                    (wr_nxt[ADDR_W-1:0] == rd_nxt[ADDR_W-1:0]);
         empty_q <= (wr_nxt == rd_nxt);
         cnt_q   <= cnt_nxt;
         rv_q    <= pop_ok;
         ovf_q   <= bus.w_en & full_q;
         udf_q   <= bus.r_en & empty_q;
      end
   end

`ifdef FIFO_ALMOST_FLAGS_EN
   logic af_q, ae_q;

   // Threshold flags track the occupancy that will hold after this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         af_q <= RST_AF;
         ae_q <= RST_AE;
      end else begin
         af_q <= (cnt_nxt >= (ADDR_W+1)'(AF_LVL));
         ae_q <= (cnt_nxt <= (ADDR_W+1)'(AE_LVL));
      end
   end

   assign bus.almost_full  = af_q;
   assign bus.almost_empty = ae_q;
`endif

   assign bus.ram_w_en   = push_ok;
   assign bus.ram_w_addr = wr_ptr[ADDR_W-1:0];
   assign bus.ram_r_addr = rd_ptr[ADDR_W-1:0];
   assign bus.r_valid    = rv_q;
   assign bus.w_full     = full_q;
   assign bus.r_empty    = empty_q;
   assign bus.fifo_cnt   = cnt_q;
   assign bus.ovf        = ovf_q;
   assign bus.udf        = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: table of directed vectors, hand sequences for
// wrap/simultaneous/reset, then random traffic against a queue model.
module tb_sync_fifo_ctrl;

   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   sync_fifo_ctrl_if #(.ADDR_W(4)) bus ();

   sync_fifo_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural dual-port RAM, registered read.
   logic [7:0] mem [DEPTH];
   logic [7:0] wdata;
   logic [7:0] rdata;
   always @(posedge clk) begin
      if (bus.ram_w_en) mem[bus.ram_w_addr] <= wdata;
      rdata <= mem[bus.ram_r_addr];
   end

   int checks = 0;
   int failures = 0;

   // Reference model: queue of stored bytes plus totals of accepted ops.
   logic [7:0] q [$];
   int  wtot, rtot;
   logic exp_rv, exp_ovf, exp_udf;
   logic [7:0] exp_rdata;
   logic [3:0] last_waddr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      wtot = 0; rtot = 0;
      exp_rv = 0; exp_ovf = 0; exp_udf = 0; exp_rdata = '0;
   endtask

   // One clock: drive, check pre-edge outputs against the model, advance.
   task automatic step(input logic w, input logic r, input logic [7:0] d);
      logic push, pop;
      @(negedge clk);
      bus.w_en = w; bus.r_en = r; wdata = d;
      #1;
      push = w && (q.size() < DEPTH);
      pop  = r && (q.size() > 0);
      last_waddr = bus.ram_w_addr;
      chk("ram_w_en",   bus.ram_w_en,   push);
      chk("ram_w_addr", bus.ram_w_addr, wtot % DEPTH);
      chk("ram_r_addr", bus.ram_r_addr, rtot % DEPTH);
      chk("w_full",     bus.w_full,     q.size() == DEPTH);
      chk("r_empty",    bus.r_empty,    q.size() == 0);
      chk("fifo_cnt",   bus.fifo_cnt,   q.size());
      chk("r_valid",    bus.r_valid,    exp_rv);
      chk("ovf",        bus.ovf,        exp_ovf);
      chk("udf",        bus.udf,        exp_udf);
      if (exp_rv) chk("r_data", rdata, exp_rdata);
`ifdef FIFO_ALMOST_FLAGS_EN
      chk("almost_full",  bus.almost_full,  q.size() >= 14);
      chk("almost_empty", bus.almost_empty, q.size() <= 2);
`endif
      @(posedge clk);
      exp_ovf = w && (q.size() == DEPTH);
      exp_udf = r && (q.size() == 0);
      exp_rv  = pop;
      if (pop)  begin exp_rdata = q.pop_front(); rtot++; end
      if (push) begin q.push_back(d); wtot++; end
   endtask

   // Mid-cycle asynchronous reset; outputs must clear before any edge.
   task automatic do_reset();
      @(negedge clk);
      bus.w_en = 1'b0; bus.r_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_r_empty",  bus.r_empty,    1);
      chk("rst_w_full",   bus.w_full,     0);
      chk("rst_cnt",      bus.fifo_cnt,   0);
      chk("rst_r_valid",  bus.r_valid,    0);
      chk("rst_ovf",      bus.ovf,        0);
      chk("rst_udf",      bus.udf,        0);
      chk("rst_w_addr",   bus.ram_w_addr, 0);
      chk("rst_r_addr",   bus.ram_r_addr, 0);
`ifdef FIFO_ALMOST_FLAGS_EN
      chk("rst_af", bus.almost_full,  0);
      chk("rst_ae", bus.almost_empty, 1);
`endif
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic w, r;
      int   cnt;
      logic full, empty, ovf, udf, rv;
   } vec_t;
   vec_t tbl [$];

   function automatic void add(input logic w, input logic r, input int cnt, input logic full,
                               input logic empty, input logic ovf, input logic udf, input logic rv);
      vec_t v;
      v.w = w; v.r = r; v.cnt = cnt; v.full = full; v.empty = empty;
      v.ovf = ovf; v.udf = udf; v.rv = rv;
      tbl.push_back(v);
   endfunction

   initial begin
      int pct_w, pct_r;
      bus.w_en = 1'b0; bus.r_en = 1'b0; wdata = '0;

      // Expected state after each edge, from a fresh reset.
      for (int i = 0; i < 16; i++) add(1, 0, i+1, i == 15, 0, 0, 0, 0);
      add(1, 0, 16, 1, 0, 1, 0, 0);                       // push at full
      for (int i = 0; i < 16; i++) add(0, 1, 15-i, 0, i == 15, 0, 0, 1);
      add(0, 1, 0, 0, 1, 0, 1, 0);                        // pop at empty
      add(1, 1, 1, 0, 0, 0, 1, 0);                        // both at empty
      add(1, 1, 1, 0, 0, 0, 0, 1);                        // both at cnt 1
      for (int i = 0; i < 15; i++) add(1, 0, i+2, i == 14, 0, 0, 0, 0);
      add(1, 1, 15, 0, 0, 1, 0, 1);                       // both at full

      #2;
      do_reset();
      step(0, 0, 8'h00);                                  // idle after reset

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].w, tbl[i].r, 8'(i));
         #2;
         chk("tbl_cnt",   bus.fifo_cnt, tbl[i].cnt);
         chk("tbl_full",  bus.w_full,   tbl[i].full);
         chk("tbl_empty", bus.r_empty,  tbl[i].empty);
         chk("tbl_ovf",   bus.ovf,      tbl[i].ovf);
         chk("tbl_udf",   bus.udf,      tbl[i].udf);
         chk("tbl_rv",    bus.r_valid,  tbl[i].rv);
      end

      // Wrap: second batch lands at 10..15,0..3 and drains intact.
      do_reset();
      for (int i = 0; i < 10; i++) step(1, 0, 8'(i));
      for (int i = 0; i < 10; i++) step(0, 1, 8'h00);
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 8'(8'hA0 + i));
         chk("wrap_addr", last_waddr, (10 + i) % DEPTH);
      end
      for (int i = 0; i < 11; i++) step(0, 1, 8'h00);

      // Steady simultaneous push+pop at occupancy 5.
      for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h50 + i));
      for (int i = 0; i < 20; i++) begin
         step(1, 1, 8'(8'h60 + i));
         #2 chk("sim5_cnt", bus.fifo_cnt, 5);
      end
      for (int i = 0; i < 6; i++) step(0, 1, 8'h00);

      // Reset mid-burst at cnt 7, next push goes to address 0.
      for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h70 + i));
      #2 chk("pre_rst_cnt", bus.fifo_cnt, 7);
      do_reset();
      step(1, 0, 8'hEE);
      chk("post_rst_addr", last_waddr, 0);
      step(0, 1, 8'h00);
      step(0, 0, 8'h00);

      // Random traffic in phases with different push/pop bias.
      for (int ph = 0; ph < 4; ph++) begin
         pct_w = (ph == 0) ? 70 : (ph == 1) ? 30 : 50;
         pct_r = (ph == 0) ? 30 : (ph == 1) ? 70 : 50;
         for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < pct_w, $urandom_range(0, 99) < pct_r, 8'($urandom));
      end
      step(0, 0, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock pointer/flag controller for the 16x8 dual-port RAM FIFO datapath. It accepts push and pop requests, gates the RAM write enable, and generates the RAM write and read addresses. It maintains the full/empty/count status and flags read-data validity. It sits between the requesting logic and the dp_ram instance, with the RAM's w_clk and r_clk both tied to clk.

Parameters:
ADDR_W, 4, RAM address width; depth = 2**ADDR_W
DEPTH, 16, entry count; must equal 2**ADDR_W (elaboration check)
AF_LVL, 14, almost-full threshold (used only with optional feature)
AE_LVL, 2, almost-empty threshold (used only with optional feature)

Ports:
clk  input  1  system clock; also drives the RAM's w_clk and r_clk
rst_n  input  1  asynchronous active-low reset
w_en  input  1  push request; data is presented to the RAM in the same cycle
r_en  input  1  pop request
ram_w_en  output  1  RAM write strobe (combinational)
ram_w_addr  output  ADDR_W  RAM write address
ram_r_addr  output  ADDR_W  RAM read address
r_valid  output  1  RAM r_data valid this cycle
w_full  output  1  FIFO full
r_empty  output  1  FIFO empty
fifo_cnt  output  ADDR_W+1  occupancy, range 0..DEPTH
ovf  output  1  one-cycle pulse: push rejected because full
udf  output  1  one-cycle pulse: pop rejected because empty

Behaviour:
- Reset (async assert, sync release): pointers=0, fifo_cnt=0, r_empty=1, w_full=0, r_valid=0, ovf=0, udf=0.
- Pointers: wr_ptr and rd_ptr, each ADDR_W+1 bits; the extra MSB is the wrap bit. ram_w_addr = wr_ptr[ADDR_W-1:0]; ram_r_addr = rd_ptr[ADDR_W-1:0].
- Accepted push: push_ok = w_en & ~w_full. ram_w_en = push_ok, combinational, so the write occurs on the same clk edge. wr_ptr increments on that edge.
- Accepted pop: pop_ok = r_en & ~r_empty. rd_ptr increments on the clk edge. RAM read is registered: r_valid is a register equal to pop_ok, so data is valid exactly 1 cycle after the accepted pop.
- Flags are registered and computed from next-state pointers, so they are accurate in the cycle following the event.
  - w_full = (wr_ptr_nxt[MSB] != rd_ptr_nxt[MSB]) & (lower bits equal).
  - r_empty = wr_ptr_nxt == rd_ptr_nxt.
- fifo_cnt is registered: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
- Simultaneous push and pop:
  - Full: pop is accepted, push is rejected (flags are evaluated on current state), ovf pulses, count becomes DEPTH-1.
  - Empty: push is accepted, pop is rejected, udf pulses, count becomes 1. No fall-through.
  - Otherwise: both are accepted, count is unchanged, flags are unchanged.
- Wrap-around: pointers roll over modulo 2*DEPTH. Address bits roll over 15->0 without a gap.
- ovf/udf are registered single-cycle pulses, one per rejected request. They are not sticky.
- Reset asserted mid-operation clears all state immediately. RAM contents are not cleared but are unreachable until rewritten.

Optional Feature:
- Macro: FIFO_ALMOST_FLAGS_EN.
- Defined: adds outputs almost_full (registered, fifo_cnt_nxt >= AF_LVL) and almost_empty (registered, fifo_cnt_nxt <= AE_LVL). Both reset to almost_full=0, almost_empty=1.
- Undefined: these ports and their logic are absent; AF_LVL and AE_LVL are unused.

Decomposition:
- Shared package fifo_pkg: ADDR_W/DEPTH defaults, data width 8, pointer width (ADDR_W+1), and reset-value constants.
- One natural sub-module, fifo_ptr: a wrap-bit pointer counter with an increment enable and a next-value output. It is instantiated twice, once for write and once for read.
- Flag and count logic stays in the top level.
- Integration wrapper (outside this block) pairs sync_fifo_ctrl with dp_ram.

Test Plan:
- Reset then idle -> r_empty=1, w_full=0, fifo_cnt=0, r_valid=0, addresses 0.
- 16 back-to-back pushes (data 0x00..0x0F) -> ram_w_addr 0..15 with ram_w_en high. w_full=1 after 16th edge, fifo_cnt=16. 17th push -> ram_w_en=0, ovf one-cycle pulse.
- 16 back-to-back pops after fill -> r_valid each cycle 1 cycle delayed, data 0x00..0x0F in order. r_empty=1 and fifo_cnt=0 after last pop. Extra pop -> udf pulse, r_valid=0.
- Wrap: push 10, pop 10, push 10 -> ram_w_addr sequence 10..15,0..3. Pop returns the second batch intact. fifo_cnt peaks at 10.
- Simultaneous push+pop at cnt=5 for 20 cycles -> fifo_cnt stays 5, flags static, FIFO-order data. Simultaneous at full -> ovf=1, count 15. Simultaneous at empty -> udf=1, count 1.
- rst_n pulsed low mid-burst at cnt=7 -> all outputs at reset values asynchronously. The next push writes address 0. With FIFO_ALMOST_FLAGS_EN: almost_full asserts at cnt 14, almost_empty deasserts at cnt 3.
